// File: rtl/encoder_speed_meter.sv
// Quadrature encoder speed meter: synchronise A/B, decode 4x, count edges per window,
// then convert the window count to RPM, signed Q15 rad/s and a direction code.
module encoder_speed_meter #(
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned SAMPLE_CYCLES = 500000,
  parameter int unsigned RPM_DATA      = 8,
  parameter int unsigned RPM_MULT      = 1164,
  parameter int unsigned RPM_SHIFT     = 8,
  parameter int unsigned N_WIDTH       = 32,
  parameter int unsigned Q_WIDTH       = 15,
  parameter int          W_MULT        = 15598
) (
  input  logic                ENCODER_SPEED_CLOCK,
  input  logic                ENCODER_SPEED_RESET_InHigh,
  input  logic                ENCODER_SPEED_ENCODERA_In,
  input  logic                ENCODER_SPEED_ENCODERB_In,
  output logic [RPM_DATA-1:0] ENCODER_SPEED_RPM_OutBus,
  output logic [N_WIDTH-1:0]  ENCODER_SPEED_W_OutBus,
  output logic [1:0]          ENCODER_SPEED_DIR_OutBus,
  output logic                ENCODER_SPEED_VALID_Out,
  output logic                ENCODER_SPEED_ERR_Out
);

  localparam int WinW  = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int AccW  = CNT_WIDTH + 1;
  localparam int RpmPW = CNT_WIDTH + 32;
  // Wide enough that the signed product never clips before the explicit saturation.
  localparam int WBase = CNT_WIDTH + 33 + Q_WIDTH;
  localparam int WPW   = (WBase > N_WIDTH + 1) ? WBase : N_WIDTH + 1;

  localparam logic [WinW-1:0]             WinLast  = WinW'(SAMPLE_CYCLES - 1);
  localparam logic signed [CNT_WIDTH-1:0] AccMax   = {1'b0, {(CNT_WIDTH-1){1'b1}}};
  localparam logic signed [CNT_WIDTH-1:0] AccMin   = ~AccMax;
  localparam logic [RpmPW-1:0]            RpmLimit = RpmPW'((64'd1 << RPM_DATA) - 64'd1);
  localparam logic signed [WPW-1:0]       WMax     = WPW'({1'b0, {(N_WIDTH-1){1'b1}}});
  localparam logic signed [WPW-1:0]       WMin     = ~WMax;

  logic                        clk, rst;
  logic                        a_meta_q, a_sync_q, b_meta_q, b_sync_q;
  logic [1:0]                  s, prev_q;
  logic                        prime_q;
  logic signed [1:0]           delta;
  logic                        illegal;
  logic signed [AccW-1:0]      acc_sum;
  logic signed [CNT_WIDTH-1:0] acc_q, acc_sat;
  logic [WinW-1:0]             win_q;
  logic                        terminal;
  logic signed [CNT_WIDTH-1:0] c_q;
  logic [CNT_WIDTH-1:0]        mag, mag_q;
  logic                        v1_q;
  logic [RpmPW-1:0]            rpm_prod, rpm_shift;
  logic [RPM_DATA-1:0]         rpm_d, rpm_q;
  logic signed [WPW-1:0]       w_prod;
  logic [N_WIDTH-1:0]          w_d, w_q;
  logic [1:0]                  dir_d, dir_q;
  logic                        valid_q, err_q;

  assign clk = ENCODER_SPEED_CLOCK;
  assign rst = ENCODER_SPEED_RESET_InHigh;
  assign s   = {a_sync_q, b_sync_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      a_meta_q <= 1'b0;
      a_sync_q <= 1'b0;
      b_meta_q <= 1'b0;
      b_sync_q <= 1'b0;
      prime_q  <= 1'b1;
      prev_q   <= 2'b00;
      err_q    <= 1'b0;
    end else begin
      a_meta_q <= ENCODER_SPEED_ENCODERA_In;
      a_sync_q <= a_meta_q;
      b_meta_q <= ENCODER_SPEED_ENCODERB_In;
      b_sync_q <= b_meta_q;
      prime_q  <= 1'b0;
      prev_q   <= s;
      err_q    <= illegal;
    end
  end

  // Prime cycle only captures PREV so the reset value of S is never counted.
  always_comb begin
    delta   = 2'sd0;
    illegal = 1'b0;
    if (!prime_q) begin
      unique case ({prev_q, s})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: delta = 2'sd1;
        4'b10_00, 4'b11_10, 4'b01_11, 4'b00_01: delta = -2'sd1;
        4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: illegal = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    acc_sum = AccW'(acc_q) + AccW'(delta);
    if (acc_sum[AccW-1] != acc_sum[AccW-2]) begin
      acc_sat = acc_sum[AccW-1] ? AccMin : AccMax;
    end else begin
      acc_sat = acc_sum[CNT_WIDTH-1:0];
    end
    terminal = (win_q == WinLast);
    mag      = acc_sat[CNT_WIDTH-1] ? -acc_sat : acc_sat;
  end

  // The terminal-cycle delta is folded into C, and ACC restarts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      win_q <= '0;
      v1_q  <= 1'b0;
      c_q   <= '0;
      mag_q <= '0;
    end else begin
      v1_q <= terminal;
      if (terminal) begin
        acc_q <= '0;
        win_q <= '0;
        c_q   <= acc_sat;
        mag_q <= mag;
      end else begin
        acc_q <= acc_sat;
        win_q <= win_q + 1'b1;
      end
    end
  end

  always_comb begin
    rpm_prod  = RpmPW'(mag_q) * RpmPW'(RPM_MULT);
    rpm_shift = rpm_prod >> RPM_SHIFT;
    rpm_d     = (rpm_shift > RpmLimit) ? '1 : rpm_shift[RPM_DATA-1:0];

    w_prod = WPW'(c_q) * WPW'(W_MULT);
    if (w_prod > WMax) begin
      w_d = WMax[N_WIDTH-1:0];
    end else if (w_prod < WMin) begin
      w_d = WMin[N_WIDTH-1:0];
    end else begin
      w_d = w_prod[N_WIDTH-1:0];
    end

    if (c_q == '0) begin
      dir_d = 2'b00;
    end else if (c_q[CNT_WIDTH-1]) begin
      dir_d = 2'b10;
    end else begin
      dir_d = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      rpm_q   <= '0;
      w_q     <= '0;
      dir_q   <= 2'b00;
    end else begin
      valid_q <= v1_q;
      if (v1_q) begin
        rpm_q <= rpm_d;
        w_q   <= w_d;
        dir_q <= dir_d;
      end
    end
  end

  assign ENCODER_SPEED_RPM_OutBus = rpm_q;
  assign ENCODER_SPEED_W_OutBus   = w_q;
  assign ENCODER_SPEED_DIR_OutBus = dir_q;
  assign ENCODER_SPEED_VALID_Out  = valid_q;
  assign ENCODER_SPEED_ERR_Out    = err_q;

endmodule

// File: tb/tb_encoder_speed_meter.sv
// Bench for encoder_speed_meter: short-window and long-window instances share one
// encoder stimulus and are compared every cycle against a window-count reference model.
module tb_encoder_speed_meter;

  localparam int SC_A = 1000;
  localparam int SC_B = 40000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enc_a, enc_b;
  logic [7:0]  rpm_a, rpm_b;
  logic [31:0] w_a, w_b;
  logic [1:0]  dir_a, dir_b;
  logic        valid_a, valid_b, err_a, err_b;

  encoder_speed_meter #(.SAMPLE_CYCLES(SC_A)) u_dut_a (
    .ENCODER_SPEED_CLOCK        (clk),
    .ENCODER_SPEED_RESET_InHigh (rst),
    .ENCODER_SPEED_ENCODERA_In  (enc_a),
    .ENCODER_SPEED_ENCODERB_In  (enc_b),
    .ENCODER_SPEED_RPM_OutBus   (rpm_a),
    .ENCODER_SPEED_W_OutBus     (w_a),
    .ENCODER_SPEED_DIR_OutBus   (dir_a),
    .ENCODER_SPEED_VALID_Out    (valid_a),
    .ENCODER_SPEED_ERR_Out      (err_a)
  );

  encoder_speed_meter #(.SAMPLE_CYCLES(SC_B)) u_dut_b (
    .ENCODER_SPEED_CLOCK        (clk),
    .ENCODER_SPEED_RESET_InHigh (rst),
    .ENCODER_SPEED_ENCODERA_In  (enc_a),
    .ENCODER_SPEED_ENCODERB_In  (enc_b),
    .ENCODER_SPEED_RPM_OutBus   (rpm_b),
    .ENCODER_SPEED_W_OutBus     (w_b),
    .ENCODER_SPEED_DIR_OutBus   (dir_b),
    .ENCODER_SPEED_VALID_Out    (valid_b),
    .ENCODER_SPEED_ERR_Out      (err_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int err_cnt_a   = 0;
  int valid_cnt_a = 0;
  int pos = 0;

  // Position around the quadrature cycle: forward is +1, reverse is -1, +2 is illegal.
  logic [1:0] code_of [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int         pos_of  [4] = '{0, 3, 1, 2};

  // Reference model state
  logic [1:0] m_meta = 2'b00, m_s = 2'b00, m_prev = 2'b00;
  bit         m_prime = 1'b1;
  bit         e_err = 1'b0;
  int         m_acc [2], m_win [2], m_pend_c [2];
  bit         m_pend [2], e_valid [2];
  longint     e_rpm [2], e_w [2], e_dir [2];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int win_len(input int k);
    return (k == 0) ? SC_A : SC_B;
  endfunction

  function automatic longint ref_rpm(input int c);
    longint m, r;
    m = (c < 0) ? -longint'(c) : longint'(c);
    r = (m * 1164) / 256;
    return (r > 255) ? 255 : r;
  endfunction

  function automatic longint ref_w(input int c);
    longint p;
    p = longint'(c) * 15598;
    if (p > 64'sd2147483647) p = 64'sd2147483647;
    if (p < -64'sd2147483648) p = -64'sd2147483648;
    return p;
  endfunction

  function automatic longint ref_dir(input int c);
    return (c > 0) ? 1 : ((c < 0) ? 2 : 0);
  endfunction

  // Advance the model by one rising edge using the inputs present before that edge.
  function automatic void model_edge();
    int d, sum, step;
    bit ill;
    if (rst) begin
      m_meta = 2'b00; m_s = 2'b00; m_prev = 2'b00; m_prime = 1'b1; e_err = 1'b0;
      for (int k = 0; k < 2; k++) begin
        m_acc[k] = 0; m_win[k] = 0; m_pend[k] = 1'b0; e_valid[k] = 1'b0;
        e_rpm[k] = 0; e_w[k] = 0; e_dir[k] = 0;
      end
    end else begin
      d = 0;
      ill = 1'b0;
      if (!m_prime) begin
        step = (pos_of[m_s] - pos_of[m_prev]) & 3;
        if (step == 1) d = 1;
        else if (step == 3) d = -1;
        else if (step == 2) ill = 1'b1;
      end
      m_prime = 1'b0;
      m_prev  = m_s;
      e_err   = ill;
      for (int k = 0; k < 2; k++) begin
        e_valid[k] = 1'b0;
        if (m_pend[k]) begin
          m_pend[k]  = 1'b0;
          e_valid[k] = 1'b1;
          e_rpm[k]   = ref_rpm(m_pend_c[k]);
          e_w[k]     = ref_w(m_pend_c[k]);
          e_dir[k]   = ref_dir(m_pend_c[k]);
        end
        sum = m_acc[k] + d;
        if (sum > 32767) sum = 32767;
        if (sum < -32768) sum = -32768;
        if (m_win[k] == win_len(k) - 1) begin
          m_pend_c[k] = sum;
          m_pend[k]   = 1'b1;
          m_acc[k]    = 0;
          m_win[k]    = 0;
        end else begin
          m_acc[k] = sum;
          m_win[k] = m_win[k] + 1;
        end
      end
      m_s    = m_meta;
      m_meta = {enc_a, enc_b};
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("a_rpm",   longint'(rpm_a),        e_rpm[0]);
    check("a_w",     longint'($signed(w_a)), e_w[0]);
    check("a_dir",   longint'(dir_a),        e_dir[0]);
    check("a_valid", longint'(valid_a),      longint'(e_valid[0]));
    check("a_err",   longint'(err_a),        longint'(e_err));
    check("b_rpm",   longint'(rpm_b),        e_rpm[1]);
    check("b_w",     longint'($signed(w_b)), e_w[1]);
    check("b_dir",   longint'(dir_b),        e_dir[1]);
    check("b_valid", longint'(valid_b),      longint'(e_valid[1]));
    check("b_err",   longint'(err_b),        longint'(e_err));
    if (err_a) err_cnt_a++;
    if (valid_a) valid_cnt_a++;
  endtask

  task automatic move(input int by);
    pos = (pos + by) & 3;
    {enc_a, enc_b} = code_of[pos];
  endtask

  task automatic wait_valid_a(input int limit);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!valid_a && n < limit);
    if (!valid_a) check("valid_a_timeout", longint'(valid_a), 1);
  endtask

  task automatic goto_win_a(input int target);
    int n;
    n = 0;
    while (m_win[0] != target && n < 2 * SC_A) begin
      tick();
      n++;
    end
  endtask

  task automatic check_window_a(input string tag, input longint rpm, input longint w,
                                input longint dir);
    check({tag, "_rpm"}, longint'(rpm_a), rpm);
    check({tag, "_w"},   longint'($signed(w_a)), w);
    check({tag, "_dir"}, longint'(dir_a), dir);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, v_before, seen, r;
    rst = 1'b1;
    pos = 0;
    {enc_a, enc_b} = 2'b00;
    tick();
    tick();
    check("rst_rpm",   longint'(rpm_a), 0);
    check("rst_w",     longint'(w_a), 0);
    check("rst_dir",   longint'(dir_a), 0);
    check("rst_valid", longint'(valid_a), 0);
    check("rst_err",   longint'(err_a), 0);
    rst = 1'b0;

    // 20 reverse steps, no ERR
    err_cnt_a = 0;
    for (int i = 0; i < 20; i++) begin
      move(-1);
      tick();
      tick();
    end
    wait_valid_a(2 * SC_A);
    check_window_a("rev20", 90, -311960, 2);
    check("rev20_err", err_cnt_a, 0);

    // Static inputs then an illegal 00 -> 11 jump
    err_cnt_a = 0;
    repeat (5) tick();
    pos = 2;
    {enc_a, enc_b} = code_of[pos];
    wait_valid_a(2 * SC_A);
    check_window_a("ill", 0, 0, 0);
    check("ill_err_cnt", err_cnt_a, 1);

    // 50 forward steps
    for (int i = 0; i < 50; i++) begin
      move(1);
      tick();
      tick();
    end
    wait_valid_a(2 * SC_A);
    check_window_a("fwd50", 227, 779900, 1);

    // One edge that reaches the decoder in the terminal cycle
    goto_win_a(SC_A - 3);
    move(1);
    wait_valid_a(2 * SC_A);
    check_window_a("edge_term", 4, 15598, 1);
    wait_valid_a(2 * SC_A);
    check_window_a("edge_next", 0, 0, 0);

    // Reset while a result is in the output pipeline
    goto_win_a(SC_A - 1);
    move(1);
    tick();
    v_before = valid_cnt_a;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("pipe_rst_novalid", valid_cnt_a - v_before, 0);

    // Reset mid-window after 30 steps, then hold A=B=1
    goto_win_a(100);
    for (int i = 0; i < 30; i++) begin
      move(1);
      tick();
    end
    rst = 1'b1;
    pos = 2;
    {enc_a, enc_b} = code_of[pos];
    tick();
    check("midrst_rpm",   longint'(rpm_a), 0);
    check("midrst_w",     longint'(w_a), 0);
    check("midrst_dir",   longint'(dir_a), 0);
    check("midrst_valid", longint'(valid_a), 0);
    rst = 1'b0;
    n = 1;
    do begin
      tick();
      n++;
    end while (!valid_a && n < SC_A + 20);
    check("midrst_valid_latency", n, SC_A + 2);
    check_window_a("prime", 0, 0, 0);

    // Randomised activity, including max-rate bursts and occasional resets
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 40) begin
      end else if (r < 65) begin
        move(1);
      end else if (r < 90) begin
        move(-1);
      end else if (r < 94) begin
        move(2);
      end else if (r < 95) begin
        rst = 1'b1;
      end
      tick();
      rst = 1'b0;
    end

    // One forward step every cycle across a long window: ACC must clamp at +32767
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < SC_B + 10; i++) begin
      move(1);
      tick();
      if (valid_b) begin
        seen++;
        check("sat_rpm", longint'(rpm_b), 255);
        check("sat_w",   longint'($signed(w_b)), 64'sd32767 * 64'sd15598);
        check("sat_dir", longint'(dir_b), 1);
      end
    end
    check("sat_valid_count", seen, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
